// File: rtl/adc_sample_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sample_packer_pkg
//  Brief    : Shared types and widths for the ADC capture packing path.
//  Revision : 1.0
// ============================================================================
package adc_sample_packer_pkg;

    localparam int SAMPLE_W = 12;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        P_A = 2'd0,
        P_B = 2'd1,
        P_C = 2'd2
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/adc_sample_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sample_packer_if
//  Brief    : Sample-in / byte-out handshake bundle of the sample packer.
//  Revision : 1.0
// ============================================================================
interface adc_sample_packer_if
    import adc_sample_packer_pkg::*;
#(
    parameter int COUNT_WIDTH = 24
);
    logic                   low_res;
    logic [SAMPLE_W-1:0]    sample_data;
    logic                   sample_valid;
    logic                   sample_ready;
    logic                   flush;
    logic                   flush_done;
    logic [BYTE_W-1:0]      byte_data;
    logic                   byte_valid;
    logic                   byte_ready;
    logic [COUNT_WIDTH-1:0] byte_count;

    // master: sample source plus byte consumer; slave: the packer itself
    modport master (
        output low_res, sample_data, sample_valid, flush, byte_ready,
        input  sample_ready, flush_done, byte_data, byte_valid, byte_count
    );

    modport slave (
        input  low_res, sample_data, sample_valid, flush, byte_ready,
        output sample_ready, flush_done, byte_data, byte_valid, byte_count
    );
endinterface
`default_nettype wire

// File: rtl/adc_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sample_packer
//  Brief    : Packs 12-bit ADC samples into bytes (2 samples -> 3 bytes, or
//             1 sample -> 1 byte in low-res), with flush and byte counting.
//  Revision : 1.0
// ============================================================================
module adc_sample_packer
    import adc_sample_packer_pkg::*;
#(
    parameter int pCOUNT_WIDTH = 24
)
(
    input  wire logic          clk_usb,
    input  wire logic          reset_n,
    adc_sample_packer_if.slave bus
);

    localparam logic [pCOUNT_WIDTH-1:0] c_COUNT_MAX = {pCOUNT_WIDTH{1'b1}};
    localparam logic [pCOUNT_WIDTH-1:0] c_COUNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;
    phase_t                  r_phase;
    phase_t                  w_phase_next;
    logic                    r_mode;
    logic                    w_mode_next;
    logic [BYTE_W-1:0]       r_store;
    logic [BYTE_W-1:0]       w_store_next;
    logic                    r_flush_pend;
    logic                    r_flush_done;
    logic                    w_flush_clr;
    logic [BYTE_W-1:0]       r_byte_data;
    logic                    r_byte_valid;
    logic [pCOUNT_WIDTH-1:0] r_count;
    logic                    w_out_free;
    logic                    w_out_xfer;
    logic                    w_load;
    logic [BYTE_W-1:0]       w_load_data;
    logic                    w_ready;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_out_free = !r_byte_valid || bus.byte_ready;
    assign w_out_xfer = r_byte_valid && bus.byte_ready;

    always_ff @(posedge clk_usb or negedge w_rst_n) begin
        if (!w_rst_n) r_phase <= P_A;
        else          r_phase <= w_phase_next;
    end

    always_comb begin
        w_phase_next = r_phase;
        w_mode_next  = r_mode;
        w_store_next = r_store;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_ready      = 1'b0;
        w_flush_clr  = 1'b0;
        case (r_phase)
            P_A: begin
                w_ready = w_out_free;
                if (bus.sample_valid && w_out_free) begin
                    w_mode_next  = bus.low_res;
                    w_load       = 1'b1;
                    w_load_data  = bus.sample_data[SAMPLE_W-1 -: BYTE_W];
                    w_store_next = {4'h0, bus.sample_data[3:0]};
                    w_phase_next = bus.low_res ? P_A : P_B;
                end else if (r_flush_pend && !r_byte_valid) begin
                    w_flush_clr = 1'b1;
                end
            end
            P_B: begin
                // A low-res group never reaches P_B; treat it as a stray state.
                if (r_mode) begin
                    w_phase_next = P_A;
                end else if (r_flush_pend) begin
                    if (w_out_free) begin
                        w_load       = 1'b1;
                        w_load_data  = {r_store[3:0], 4'h0};
                        w_phase_next = P_A;
                    end
                end else begin
                    w_ready = w_out_free;
                    if (bus.sample_valid && w_out_free) begin
                        w_load       = 1'b1;
                        w_load_data  = {r_store[3:0], bus.sample_data[SAMPLE_W-1 -: 4]};
                        w_store_next = bus.sample_data[BYTE_W-1:0];
                        w_phase_next = P_C;
                    end
                end
            end
            P_C: begin
                if (r_mode) begin
                    w_phase_next = P_A;
                end else if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_data  = r_store;
                    w_phase_next = P_A;
                end
            end
            default: w_phase_next = P_A;
        endcase
    end

    always_ff @(posedge clk_usb or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mode       <= 1'b0;
            r_store      <= '0;
            r_flush_pend <= 1'b0;
            r_flush_done <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_count      <= '0;
        end else begin
            r_mode       <= w_mode_next;
            r_store      <= w_store_next;
            r_flush_pend <= (r_flush_pend && !w_flush_clr) || bus.flush;
            r_flush_done <= w_flush_clr;
            if (w_load) begin
                r_byte_data  <= w_load_data;
                r_byte_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_byte_valid <= 1'b0;
            end
            if (w_out_xfer && (r_count != c_COUNT_MAX))
                r_count <= r_count + c_COUNT_ONE;
        end
    end

    assign bus.sample_ready = w_ready && w_rst_n;
    assign bus.flush_done   = r_flush_done;
    assign bus.byte_data    = r_byte_data;
    assign bus.byte_valid   = r_byte_valid;
    assign bus.byte_count   = r_count;

endmodule
`default_nettype wire

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Sits between the ADC sample FIFO output and the USB streaming read path.
- Converts a stream of 12-bit ADC samples into the byte stream the host reads from the streaming data register.
- Full-res mode: two samples become three bytes. Low-res mode: one sample becomes one byte (top 8 bits).
- Handles flushing of a trailing odd sample and counts emitted bytes for the capture-length status register.

Parameters:
pCOUNT_WIDTH, 24, width of the emitted-byte counter (saturates, does not wrap).

Ports:
clk_usb  input  1  USB-domain clock; all logic is on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
low_res  input  1  1 = 8 bits per sample; 0 = 12-bit packing. Latched only at group boundaries.
sample_data  input  12  ADC sample from the FIFO.
sample_valid  input  1  sample_data is valid.
sample_ready  output  1  packer accepts sample_data this cycle.
flush  input  1  single-cycle request to emit any pending partial byte.
flush_done  output  1  one-cycle pulse when the flush has completed.
byte_data  output  8  packed output byte.
byte_valid  output  1  byte_data is valid.
byte_ready  input  1  the USB read side consumes byte_data this cycle.
byte_count  output  pCOUNT_WIDTH  number of bytes accepted by the consumer since reset.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs are 0; phase = P_A; flush_pend = 0; latched mode = 0.
- Transfers:
  - Output transfer when byte_valid && byte_ready.
  - Input transfer when sample_valid && sample_ready.
- Output register: single stage. byte_data is held stable while byte_valid && !byte_ready. The register loads when it is empty or being consumed (out_free).
- State machine (phase):
  - P_A:
    - sample_ready = out_free.
    - On input transfer: latch the current low_res into mode.
    - Full-res: emit A[11:4], store A[3:0], go to P_B.
    - Low-res: emit A[11:4], stay in P_A.
  - P_B:
    - sample_ready = out_free.
    - On input transfer: emit {A[3:0], B[11:8]}, store B[7:0], go to P_C.
  - P_C:
    - sample_ready = 0.
    - When out_free: emit stored B[7:0], go to P_A. No input is consumed.
- Latency: one cycle from input transfer to byte_valid.
- Throughput: full-res is 2 samples per 3 cycles; low-res is 1 sample per cycle (with byte_ready held high).
- low_res changes in P_B or P_C are ignored until the next P_A accept. A byte stream never mixes modes within a group.
- Flush:
  - A flush pulse sets flush_pend. flush_pend is cleared when the flush is handled.
  - P_A with flush_pend: clear it and pulse flush_done the next cycle once the output register is empty (no pending byte).
  - P_B with flush_pend:
    - When out_free and no input transfer this cycle: emit {A[3:0], 4'h0}, go to P_A.
    - flush_done pulses after that byte is consumed.
  - P_C with flush_pend: finish the B[7:0] byte first, then handle as P_A.
  - In P_B, flush_pend blocks sample_ready until the pad byte is emitted.
  - Simultaneous flush and input transfer: the sample is accepted first; the flush is serviced from the resulting phase.
- byte_count increments on every output transfer and saturates at all-ones.
- Reset mid-group discards the stored nibble/byte with no pad. Any output byte in flight is dropped.

Decomposition:
- Shared package (e.g. the capture-path package): phase enum P_A/P_B/P_C, SAMPLE_W = 12, BYTE_W = 8.
- No sub-modules. The saturating counter is inline.

Test Plan:
- Full-res ramp:
  - Stimulus: low_res = 0; samples 0x001–0x006; byte_ready held high.
  - Required bytes: 00 10 02 00 30 04 00 50 06.
  - Required: byte_count = 9; 90-sample ramp decodes with zero errors.
- Low-res ramp:
  - Stimulus: low_res = 1; samples 0x000, 0x010, …, 0xFF0 (step 0x010).
  - Required bytes: 00, 01, …, FF (consecutive, modulo 256).
  - Required: one byte per cycle; sample_ready never drops.
- Flush odd sample:
  - Stimulus: full-res; sample 0x123, then flush.
  - Required: bytes 12, 30; flush_done pulses once; phase returns to P_A. The next sample 0xABC emits AB.
- Backpressure:
  - Stimulus: byte_ready = 0 for 5 cycles during the P_B byte.
  - Required: byte_data held at its value; sample_ready = 0 throughout; no sample lost; sequence resumes correctly.
- Mode change mid-group:
  - Stimulus: toggle low_res to 1 while in P_B.
  - Required: the group completes as 3 bytes; the next sample is emitted as 1 byte.
- Reset mid-group:
  - Stimulus: assert reset_n = 0 during P_C.
  - Required: outputs go to 0 immediately; the next stream starts at P_A; byte_count = 0.
